// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between the instruction-fetch
// port and the load/store port. One transaction is outstanding at a time;
// ties between the two sides are broken round-robin.
module sram_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // instruction side
   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   // data side
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   // shared bus
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_sel;        // 0 = inst, 1 = data
   logic              r_last_sel;   // side granted most recently
   logic              r_bus_req;
   logic              r_bus_wr;
   logic [1:0]        r_bus_size;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_wdata;

   logic w_any_req;
   logic w_grant_data;
   logic w_addr_hs;
   logic w_data_hs;

   // On a tie the side opposite to the last grant wins.
   assign w_any_req    = inst_req | data_req;
   assign w_grant_data = data_req & (~inst_req | ~r_last_sel);

   // Handshakes are only honoured in the phase that expects them.
   assign w_addr_hs = (r_state == S_ADDR) & bus_addr_ok;
   assign w_data_hs = (r_state == S_WAIT) & bus_data_ok;

   // Arbitration FSM: grant in IDLE, hold bus fields in ADDR, await data in WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sel       <= 1'b0;
         r_last_sel  <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_wr    <= 1'b0;
         r_bus_size  <= 2'd0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_sel       <= w_grant_data;
                  r_last_sel  <= w_grant_data;
                  r_bus_wr    <= w_grant_data ? data_wr    : inst_wr;
                  r_bus_size  <= w_grant_data ? data_size  : inst_size;
                  r_bus_addr  <= w_grant_data ? data_addr  : inst_addr;
                  r_bus_wdata <= w_grant_data ? data_wdata : inst_wdata;
                  r_bus_req   <= 1'b1;
                  r_state     <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (bus_addr_ok) begin
                  r_bus_req <= 1'b0;
                  r_state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus_data_ok) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_bus_req <= 1'b0;
            end
         endcase
      end
   end

   assign bus_req   = r_bus_req;
   assign bus_wr    = r_bus_wr;
   assign bus_size  = r_bus_size;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;

   // Handshakes are routed combinationally so the requester sees them in the bus cycle.
   assign inst_addr_ok = w_addr_hs & ~r_sel;
   assign data_addr_ok = w_addr_hs &  r_sel;
   assign inst_data_ok = w_data_hs & ~r_sel;
   assign data_data_ok = w_data_hs &  r_sel;

   assign inst_rdata = bus_rdata;
   assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Testbench for sram_bus_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model.
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size, bus_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;

   always #5 clk = ~clk;

   sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: one outstanding transaction record plus the side served last.
   bit          m_busy, m_in_data, m_owner, m_last;
   logic        m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata;
   bit          m_aok [2];
   int          obs_addr_ok_cnt, obs_data_ok_cnt;
   int          rr_order [$];

   typedef struct {
      bit          act;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } rq_t;
   rq_t ag [2];

   function automatic void model_reset();
      m_busy = 0; m_in_data = 0; m_owner = 0; m_last = 0;
      m_aok[0] = 0; m_aok[1] = 0;
   endfunction

   task automatic clear_inputs();
      inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
      bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_bus_req"}, bus_req, 0);
      check_eq({tag, "_bus_wr"}, bus_wr, 0);
      check_eq({tag, "_bus_size"}, bus_size, 0);
      check_eq({tag, "_bus_addr"}, bus_addr, 0);
      check_eq({tag, "_bus_wdata"}, bus_wdata, 0);
      check_eq({tag, "_oks"}, {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
   endtask

   // Called at a negedge after inputs are set: compare, advance model, move to next negedge.
   task automatic tick();
      logic e_req, e_iaok, e_daok, e_idok, e_ddok, g;
      #1;
      e_req  = m_busy && !m_in_data;
      e_iaok = e_req && !m_owner && bus_addr_ok;
      e_daok = e_req &&  m_owner && bus_addr_ok;
      e_idok = m_busy && m_in_data && !m_owner && bus_data_ok;
      e_ddok = m_busy && m_in_data &&  m_owner && bus_data_ok;
      check_eq("bus_req", bus_req, e_req);
      if (e_req) begin
         check_eq("bus_wr", bus_wr, m_wr);
         check_eq("bus_size", bus_size, m_size);
         check_eq("bus_addr", bus_addr, m_addr);
         check_eq("bus_wdata", bus_wdata, m_wdata);
      end
      check_eq("inst_addr_ok", inst_addr_ok, e_iaok);
      check_eq("data_addr_ok", data_addr_ok, e_daok);
      check_eq("inst_data_ok", inst_data_ok, e_idok);
      check_eq("data_data_ok", data_data_ok, e_ddok);
      check_eq("inst_rdata", inst_rdata, bus_rdata);
      check_eq("data_rdata", data_rdata, bus_rdata);
      if (inst_addr_ok) rr_order.push_back(0);
      if (data_addr_ok) rr_order.push_back(1);
      obs_addr_ok_cnt += int'(inst_addr_ok) + int'(data_addr_ok);
      obs_data_ok_cnt += int'(inst_data_ok) + int'(data_data_ok);
      m_aok[0] = e_iaok;
      m_aok[1] = e_daok;
      if (!m_busy) begin
         if (inst_req || data_req) begin
            g = (inst_req && data_req) ? !m_last : data_req;
            m_wr    = g ? data_wr    : inst_wr;
            m_size  = g ? data_size  : inst_size;
            m_addr  = g ? data_addr  : inst_addr;
            m_wdata = g ? data_wdata : inst_wdata;
            m_owner = g; m_last = g; m_busy = 1; m_in_data = 0;
         end
      end else if (!m_in_data) begin
         if (bus_addr_ok) m_in_data = 1;
      end else if (bus_data_ok) begin
         m_busy = 0;
      end
      @(negedge clk);
   endtask

   // Reset sequence; returns at a negedge with rst released and inputs idle.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1;
      clear_inputs();
      #1;
      check_all_zero(tag);
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      model_reset();
      @(negedge clk);
      check_all_zero("reset");
      rst = 0;

      // Single inst read
      obs_addr_ok_cnt = 0; obs_data_ok_cnt = 0;
      inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0000;
      tick();
      bus_addr_ok = 1;
      #1;
      check_eq("rd_bus_req_c1", bus_req, 1);
      check_eq("rd_bus_addr", bus_addr, 32'hBFC0_0000);
      check_eq("rd_inst_addr_ok_c1", inst_addr_ok, 1);
      tick();
      inst_req = 0; bus_addr_ok = 0;
      tick();
      bus_data_ok = 1; bus_rdata = 32'h3C08_BFC0;
      #1;
      check_eq("rd_inst_data_ok_c3", inst_data_ok, 1);
      check_eq("rd_inst_rdata", inst_rdata, 32'h3C08_BFC0);
      tick();
      bus_data_ok = 0;
      tick();
      check_eq("rd_pulses", {obs_addr_ok_cnt[7:0], obs_data_ok_cnt[7:0]}, 16'h0101);

      // Simultaneous requests after reset: data wins the first tie
      do_reset("rst2");
      data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
      inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC0_0004;
      tick();
      bus_addr_ok = 1;
      #1;
      check_eq("sim_bus_wr", bus_wr, 1);
      check_eq("sim_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
      check_eq("sim_data_addr_ok", data_addr_ok, 1);
      tick();
      data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
      tick();
      bus_data_ok = 0;
      tick();
      #1;
      check_eq("sim_inst_granted", bus_req, 1);
      check_eq("sim_inst_addr", bus_addr, 32'hBFC0_0004);
      bus_addr_ok = 1;
      tick();
      inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
      tick();
      bus_data_ok = 0;

      // Round-robin with both sides requesting continuously
      do_reset("rst3");
      rr_order.delete();
      for (int c = 0; c < 12; c++) begin
         inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h0000_1000;
         data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h0000_2000; data_wdata = 32'h5A5A_0000 + c;
         bus_addr_ok = m_busy && !m_in_data;
         bus_data_ok = m_busy && m_in_data;
         tick();
      end
      clear_inputs();
      tick();
      check_eq("rr_count", rr_order.size(), 4);
      for (int i = 0; i < 4 && i < rr_order.size(); i++)
         check_eq($sformatf("rr_grant%0d", i), rr_order[i], (i % 2 == 0) ? 1 : 0);

      // Bus wait states: addr_ok 3 cycles late, data_ok 5 cycles further
      obs_addr_ok_cnt = 0; obs_data_ok_cnt = 0;
      inst_req = 1; inst_size = 2; inst_addr = 32'h0000_0040;
      tick();
      for (int c = 0; c < 3; c++) tick();
      bus_addr_ok = 1;
      tick();
      inst_req = 0; bus_addr_ok = 0;
      for (int c = 0; c < 5; c++) tick();
      bus_data_ok = 1; bus_rdata = 32'h1234_ABCD;
      tick();
      bus_data_ok = 0;
      tick();
      check_eq("ws_addr_ok_pulses", obs_addr_ok_cnt, 1);
      check_eq("ws_data_ok_pulses", obs_data_ok_cnt, 1);

      // Reset in WAIT: abandon the store, then serve a fresh fetch
      obs_data_ok_cnt = 0;
      data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_0020; data_wdata = 32'h1234_5678;
      tick();
      bus_addr_ok = 1;
      tick();
      data_req = 0; bus_addr_ok = 0;
      #2;
      rst = 1;
      bus_data_ok = 1;
      #1;
      check_all_zero("rst_wait");
      @(negedge clk);
      #1;
      check_eq("rst_wait_no_data_ok", {inst_data_ok, data_data_ok}, 0);
      obs_data_ok_cnt += int'(inst_data_ok) + int'(data_data_ok);
      @(negedge clk);
      rst = 0;
      model_reset();
      clear_inputs();
      inst_req = 1; inst_size = 2; inst_addr = 32'h0000_0080;
      tick();
      bus_addr_ok = 1;
      tick();
      inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hCAFE_0001;
      #1;
      check_eq("post_rst_inst_data_ok", inst_data_ok, 1);
      tick();
      bus_data_ok = 0;
      tick();
      check_eq("rst_wait_data_ok_total", obs_data_ok_cnt, 1);

      // Byte store
      data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AB;
      tick();
      bus_addr_ok = 1;
      #1;
      check_eq("byte_bus_size", bus_size, 0);
      check_eq("byte_bus_addr", bus_addr, 32'h8000_0003);
      check_eq("byte_bus_wdata", bus_wdata, 32'h0000_00AB);
      tick();
      data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
      #1;
      check_eq("byte_data_data_ok", data_data_ok, 1);
      tick();
      bus_data_ok = 0;
      tick();

      // Randomized traffic against the model
      do_reset("rst4");
      ag[0].act = 0; ag[1].act = 0;
      for (int c = 0; c < 2000; c++) begin
         for (int s = 0; s < 2; s++) begin
            if (ag[s].act && m_aok[s]) ag[s].act = 0;
            if (!ag[s].act && $urandom_range(0, 9) < 4) begin
               ag[s].act   = 1;
               ag[s].wr    = 1'($urandom_range(0, 1));
               ag[s].size  = 2'($urandom_range(0, 2));
               ag[s].addr  = $urandom;
               ag[s].wdata = $urandom;
            end
         end
         inst_req = ag[0].act; inst_wr = ag[0].wr; inst_size = ag[0].size;
         inst_addr = ag[0].addr; inst_wdata = ag[0].wdata;
         data_req = ag[1].act; data_wr = ag[1].wr; data_size = ag[1].size;
         data_addr = ag[1].addr; data_wdata = ag[1].wdata;
         bus_addr_ok = 0; bus_data_ok = 0;
         if (m_busy && !m_in_data) begin
            bus_addr_ok = ($urandom_range(0, 2) == 0);
            if (!bus_addr_ok) bus_data_ok = ($urandom_range(0, 4) == 0);
         end else if (m_busy) begin
            bus_data_ok = ($urandom_range(0, 2) == 0);
         end else begin
            bus_addr_ok = ($urandom_range(0, 4) == 0);
            bus_data_ok = ($urandom_range(0, 4) == 0);
         end
         bus_rdata = $urandom;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
